// File: rtl/spi_pkg.sv
// Shared SPI definitions for the master and slave ends of the link:
// mode encodings, the frame state enum and the synchroniser depth.
package spi_pkg;

  localparam logic CPOL_MODE0 = 1'b0;
  localparam logic CPHA_MODE0 = 1'b0;
  localparam logic [1:0] SPI_MODE0 = {CPOL_MODE0, CPHA_MODE0};

  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with an optional extra
// flop that turns the synchronised level into 1-cycle rise/fall strobes.
import spi_pkg::*;

module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0,
  parameter bit   EDGE_DET  = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= {SYNC_STAGES{RESET_VAL}};
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

  generate
    if (EDGE_DET) begin : g_edge
      logic edge_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) edge_q <= RESET_VAL;
        else       edge_q <= sync_o;
      end

      assign rise_o = sync_o & ~edge_q;
      assign fall_o = ~sync_o & edge_q;
    end else begin : g_no_edge
      assign rise_o = 1'b0;
      assign fall_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversamples sclk/mosi/ss_n in the clk domain,
// deserialises words from mosi and shifts a preloaded word out on miso.
import spi_pkg::*;

module spi_slave #(
  parameter int unsigned BITS = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            sclk_i,
  input  logic            mosi_i,
  input  logic            ss_n_i,
  output logic            miso_o,
  input  logic [BITS-1:0] data_in_i,
  input  logic            data_load_i,
  output logic [BITS-1:0] data_out_o,
  output logic            data_valid_o,
  output logic            busy_o,
  output logic            tx_empty_o
);

  localparam int unsigned CNT_W = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS - 1);

  logic sclk_rise, sclk_fall, sclk_sync_unused;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.RESET_VAL(1'b0), .EDGE_DET(1'b1)) u_sync_sclk (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(sclk_i),
    .sync_o(sclk_sync_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1), .EDGE_DET(1'b1)) u_sync_ss (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(ss_n_i),
    .sync_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b0), .EDGE_DET(1'b0)) u_sync_mosi (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(mosi_i),
    .sync_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  spi_state_e       state_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [BITS-1:0]  shift_q, shift_d, tx_buf_q, data_out_q;
  logic             miso_q, data_valid_q, tx_empty_q, got_rise_q;
  logic [1:0]       settle_q;
  logic             armed_q;

  assign shift_d = {shift_q[BITS-2:0], mosi_s};

  // The synchroniser resets to ss_n=1, so a pin already low at reset release
  // looks like a fall; frames only start once ss_n has been seen truly high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      tx_buf_q     <= '0;
      data_out_q   <= '0;
      miso_q       <= 1'b0;
      data_valid_q <= 1'b0;
      tx_empty_q   <= 1'b1;
      got_rise_q   <= 1'b0;
      settle_q     <= '0;
      armed_q      <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      if (settle_q != 2'(SYNC_STAGES)) settle_q <= settle_q + 2'd1;
      armed_q <= armed_q | ((settle_q == 2'(SYNC_STAGES)) & ss_s);

      if (data_load_i) tx_buf_q <= data_in_i;

      case (state_q)
        IDLE: begin
          if (ss_fall && armed_q) begin
            state_q    <= ACTIVE;
            bit_cnt_q  <= '0;
            shift_q    <= tx_buf_q;
            miso_q     <= tx_buf_q[BITS-1];
            tx_empty_q <= 1'b1;
            got_rise_q <= 1'b0;
          end
        end
        ACTIVE: begin
          if (sclk_rise) begin
            shift_q    <= shift_d;
            got_rise_q <= 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              data_out_q   <= shift_d;
              data_valid_q <= 1'b1;
              bit_cnt_q    <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end else if (sclk_fall && got_rise_q) begin
            if (bit_cnt_q == '0) begin
              shift_q    <= tx_buf_q;
              miso_q     <= tx_buf_q[BITS-1];
              tx_empty_q <= 1'b1;
            end else begin
              miso_q <= shift_q[BITS-1];
            end
          end
          // Placed after the rise handling so a coincident final bit still completes.
          if (ss_rise) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            miso_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (data_load_i) tx_empty_q <= 1'b0;
    end
  end

  assign miso_o       = miso_q;
  assign data_out_o   = data_out_q;
  assign data_valid_o = data_valid_q;
  assign busy_o       = (state_q == ACTIVE);
  assign tx_empty_o   = tx_empty_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a behavioural mode-0 master drives frames
// at clk/8 while a scoreboard matches every data_valid against queued words.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, mosi, ssN, miso;
  logic [7:0] dataIn, dataOut;
  logic       dataLoad, dataValid, busy, txEmpty;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0]  expRx[$];
  logic [7:0]  expWord;
  logic [15:0] misoWord;

  always #1 clk = ~clk;

  spi_slave #(.BITS(8)) dut (
    .clk_i(clk), .rst_i(rst), .sclk_i(sclk), .mosi_i(mosi), .ss_n_i(ssN),
    .miso_o(miso), .data_in_i(dataIn), .data_load_i(dataLoad),
    .data_out_o(dataOut), .data_valid_o(dataValid), .busy_o(busy),
    .tx_empty_o(txEmpty)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic loadWord(input logic [7:0] val);
    dataIn   = val;
    dataLoad = 1'b1;
    #2;
    dataLoad = 1'b0;
  endtask

  // Shifts nbits of w (MSB first) with ss_n already low; returns what miso carried.
  task automatic spiBits(input logic [15:0] w, input int nbits, input int loadAt,
                         input logic [7:0] loadVal, output logic [15:0] rxMiso);
    rxMiso = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = w[nbits-1-i];
      #8;
      rxMiso = {rxMiso[14:0], miso};
      sclk = 1'b1;
      #8;
      sclk = 1'b0;
      if (i == loadAt) loadWord(loadVal);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] w, input int nbits, input int loadAt,
                               input logic [7:0] loadVal, output logic [15:0] rxMiso);
    ssN = 1'b0;
    #16;
    checkOutput("busy_active", 32'(busy), 32'd1);
    spiBits(w, nbits, loadAt, loadVal, rxMiso);
    #8;
    ssN = 1'b1;
    #16;
    checkOutput("busy_idle", 32'(busy), 32'd0);
    checkOutput("miso_idle", 32'(miso), 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_miso"},     32'(miso),      32'd0);
    checkOutput({tag, "_valid"},    32'(dataValid), 32'd0);
    checkOutput({tag, "_busy"},     32'(busy),      32'd0);
    checkOutput({tag, "_tx_empty"}, 32'(txEmpty),   32'd1);
    checkOutput({tag, "_data_out"}, 32'(dataOut),   32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && dataValid) begin
      if (expRx.size() == 0) begin
        checkOutput("valid_unexpected", 32'(dataValid), 32'd0);
      end else begin
        expWord = expRx.pop_front();
        checkOutput("rx_word", 32'(dataOut), 32'(expWord));
      end
    end
  end

  initial begin
    #100000;
    failCount++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; ssN = 1'b1;
    dataIn = '0; dataLoad = 1'b0;
    #8;
    rst = 1'b0;
    #2;
    checkResetValues("reset");
    #10;

    $display("[TB] single frame");
    loadWord(8'hA5);
    checkOutput("tx_empty_loaded", 32'(txEmpty), 32'd0);
    expRx.push_back(8'h35);
    applyStimulus(16'h0035, 8, -1, 8'h00, misoWord);
    checkOutput("miso_single", 32'(misoWord[7:0]), 32'hA5);
    checkOutput("tx_empty_after", 32'(txEmpty), 32'd1);

    $display("[TB] back-to-back");
    expRx.push_back(8'h01);
    expRx.push_back(8'hFE);
    applyStimulus(16'h01FE, 16, 3, 8'h3C, misoWord);
    checkOutput("miso_b2b", 32'(misoWord), 32'hA53C);
    checkOutput("tx_empty_b2b", 32'(txEmpty), 32'd1);

    $display("[TB] abort");
    ssN = 1'b0;
    #16;
    spiBits(16'h00FF, 5, -1, 8'h00, misoWord);
    #8;
    ssN = 1'b1;
    #16;
    checkOutput("abort_hold", 32'(dataOut), 32'hFE);
    expRx.push_back(8'h81);
    applyStimulus(16'h0081, 8, -1, 8'h00, misoWord);
    checkOutput("miso_after_abort", 32'(misoWord[7:0]), 32'h3C);

    $display("[TB] empty retransmit");
    expRx.push_back(8'h77);
    applyStimulus(16'h0077, 8, -1, 8'h00, misoWord);
    checkOutput("miso_retx", 32'(misoWord[7:0]), 32'h3C);
    checkOutput("tx_empty_retx", 32'(txEmpty), 32'd1);

    $display("[TB] reset mid-frame");
    ssN = 1'b0;
    #16;
    spiBits(16'h00C3, 4, -1, 8'h00, misoWord);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    checkResetValues("midreset");
    #20;
    checkOutput("midreset_stay_idle", 32'(busy), 32'd0);
    ssN = 1'b1;
    #16;
    expRx.push_back(8'h5A);
    applyStimulus(16'h005A, 8, -1, 8'h00, misoWord);
    checkOutput("miso_post_reset", 32'(misoWord[7:0]), 32'h00);

    #20;
    checkOutput("rx_drain", 32'(expRx.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
